// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two requesters (imem, dmem), the shared memory port and mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;

    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  mem_rdata, mem_resp,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        output mem_addr, mem_rmask, mem_wmask, mem_wdata
    );

    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output mem_rdata, mem_resp,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp,
        input  mem_addr, mem_rmask, mem_wmask, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one pending slot per requester, dmem-first priority with a
// bounded dmem streak so a waiting imem request is never starved.
module mem_arbiter #(
    parameter int DPRIO_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         err
);
    localparam int SW = $clog2(DPRIO_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(DPRIO_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_i_valid;
    logic [31:0]   r_i_addr;
    logic [3:0]    r_i_rmask;
    logic          r_d_valid;
    logic [31:0]   r_d_addr;
    logic [3:0]    r_d_rmask;
    logic [3:0]    r_d_wmask;
    logic [31:0]   r_d_wdata;

    logic [SW-1:0] r_streak;
    logic [SW-1:0] w_streak_nxt;
    logic          r_err;

    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_rmask;
    logic [3:0]    r_mem_wmask;
    logic [31:0]   r_mem_wdata;

    logic          w_resp_i;
    logic          w_resp_d;
    logic          w_i_pulse;
    logic          w_d_pulse;
    logic          w_i_hold;
    logic          w_d_hold;
    logic          w_i_accept;
    logic          w_d_accept;
    logic          w_i_pend;
    logic          w_d_pend;
    logic          w_arb;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_err_evt;
    logic [31:0]   w_i_addr_sel;
    logic [3:0]    w_i_rmask_sel;
    logic [31:0]   w_d_addr_sel;
    logic [3:0]    w_d_rmask_sel;
    logic [3:0]    w_d_wmask_sel;
    logic [31:0]   w_d_wdata_sel;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: slot occupancy, arbitration and streak bookkeeping
    always_comb begin
        w_i_pulse  = |bus.imem_rmask;
        w_d_pulse  = (|bus.dmem_rmask) | (|bus.dmem_wmask);
        // A slot being released by this cycle's response may take a new pulse.
        w_i_hold   = r_i_valid & ~w_resp_i;
        w_d_hold   = r_d_valid & ~w_resp_d;
        w_i_accept = w_i_pulse & ~w_i_hold;
        w_d_accept = w_d_pulse & ~w_d_hold;
        w_err_evt  = (w_i_pulse & w_i_hold) | (w_d_pulse & w_d_hold)
                   | ((r_state == IDLE) & bus.mem_resp);
        // Waiting, not in flight.
        w_i_pend   = (w_i_hold & (r_state != BUSY_I)) | w_i_accept;
        w_d_pend   = (w_d_hold & (r_state != BUSY_D)) | w_d_accept;
        w_arb      = (r_state == IDLE) | bus.mem_resp;

        w_i_addr_sel  = w_i_hold ? r_i_addr  : bus.imem_addr;
        w_i_rmask_sel = w_i_hold ? r_i_rmask : bus.imem_rmask;
        w_d_addr_sel  = w_d_hold ? r_d_addr  : bus.dmem_addr;
        w_d_rmask_sel = w_d_hold ? r_d_rmask : bus.dmem_rmask;
        w_d_wmask_sel = w_d_hold ? r_d_wmask : bus.dmem_wmask;
        w_d_wdata_sel = w_d_hold ? r_d_wdata : bus.dmem_wdata;

        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (w_arb) begin
            if (w_i_pend && (!w_d_pend || (r_streak == STREAK_MAX))) begin
                w_grant_i = 1'b1;
            end else if (w_d_pend) begin
                w_grant_d = 1'b1;
            end else begin
                w_grant_i = 1'b0;
            end
        end else begin
            w_grant_d = 1'b0;
        end

        w_state_nxt = r_state;
        if (w_grant_i) begin
            w_state_nxt = BUSY_I;
        end else if (w_grant_d) begin
            w_state_nxt = BUSY_D;
        end else if (w_arb) begin
            w_state_nxt = IDLE;
        end else begin
            w_state_nxt = r_state;
        end

        w_streak_nxt = r_streak;
        if (w_grant_i || !w_i_pend) begin
            w_streak_nxt = {SW{1'b0}};
        end else if (w_grant_d && (r_streak != STREAK_MAX)) begin
            w_streak_nxt = r_streak + SW'(1);
        end else begin
            w_streak_nxt = r_streak;
        end
    end

    // Output logic: response strobes follow mem_resp in the matching busy state
    always_comb begin
        w_resp_i = 1'b0;
        w_resp_d = 1'b0;
        case (r_state)
            BUSY_I:  w_resp_i = bus.mem_resp;
            BUSY_D:  w_resp_d = bus.mem_resp;
            default: begin
                w_resp_i = 1'b0;
                w_resp_d = 1'b0;
            end
        endcase
    end

    assign bus.imem_resp  = w_resp_i;
    assign bus.imem_rdata = w_resp_i ? bus.mem_rdata : 32'd0;
    assign bus.dmem_resp  = w_resp_d;
    assign bus.dmem_rdata = w_resp_d ? bus.mem_rdata : 32'd0;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_rmask  = r_mem_rmask;
    assign bus.mem_wmask  = r_mem_wmask;
    assign bus.mem_wdata  = r_mem_wdata;
    assign err            = r_err;

    // Pending slots, streak counter and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_valid <= 1'b0;
            r_i_addr  <= 32'd0;
            r_i_rmask <= 4'd0;
            r_d_valid <= 1'b0;
            r_d_addr  <= 32'd0;
            r_d_rmask <= 4'd0;
            r_d_wmask <= 4'd0;
            r_d_wdata <= 32'd0;
            r_streak  <= {SW{1'b0}};
            r_err     <= 1'b0;
        end else begin
            r_i_valid <= w_i_hold | w_i_accept;
            r_d_valid <= w_d_hold | w_d_accept;
            if (w_i_accept) begin
                r_i_addr  <= bus.imem_addr;
                r_i_rmask <= bus.imem_rmask;
            end
            if (w_d_accept) begin
                r_d_addr  <= bus.dmem_addr;
                r_d_rmask <= bus.dmem_rmask;
                r_d_wmask <= bus.dmem_wmask;
                r_d_wdata <= bus.dmem_wdata;
            end
            r_streak <= w_streak_nxt;
            r_err    <= r_err | w_err_evt;
        end
    end

    // Memory command register: masks live for the first busy cycle only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= 32'd0;
            r_mem_rmask <= 4'd0;
            r_mem_wmask <= 4'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_mem_rmask <= 4'd0;
            r_mem_wmask <= 4'd0;
            if (w_grant_i) begin
                r_mem_addr  <= w_i_addr_sel;
                r_mem_rmask <= w_i_rmask_sel;
                r_mem_wdata <= 32'd0;
            end else if (w_grant_d) begin
                r_mem_addr  <= w_d_addr_sel;
                r_mem_rmask <= w_d_rmask_sel;
                r_mem_wmask <= w_d_wmask_sel;
                r_mem_wdata <= w_d_wdata_sel;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a request-level model.
module tb_mem_arbiter;
    localparam int DPRIO = 4;

    logic clk = 1'b0;
    logic rst;
    logic err;

    mem_arbiter_if bus();

    mem_arbiter #(.DPRIO_MAX(DPRIO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .err (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: waiting requests, who owns the memory, and what the memory should see.
    bit   m_i_wait, m_d_wait;
    req_t m_i_req, m_d_req, m_cur;
    int   m_who;      // 0 none, 1 imem, 2 dmem
    bit   m_issue;    // this cycle is the first cycle of a transaction
    int   m_streak;
    bit   m_err;
    bit   auto_mem;
    int   mem_delay;

    logic        obs_i_resp, obs_d_resp, obs_err;
    logic [31:0] obs_i_rdata, obs_d_rdata, obs_addr;
    logic [3:0]  obs_rmask, obs_wmask;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_i_wait = 1'b0; m_d_wait = 1'b0; m_who = 0; m_issue = 1'b0;
        m_streak = 0; m_err = 1'b0; m_cur = '0; m_i_req = '0; m_d_req = '0;
    endtask

    task automatic clear_inputs();
        bus.imem_rmask = 4'h0; bus.dmem_rmask = 4'h0; bus.dmem_wmask = 4'h0; bus.mem_resp = 1'b0;
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model, then set up the next cycle.
    task automatic step();
        bit   resp_here, i_pulse, d_pulse;
        int   n_who, grant;
        @(negedge clk);
        obs_i_resp = bus.imem_resp; obs_i_rdata = bus.imem_rdata;
        obs_d_resp = bus.dmem_resp; obs_d_rdata = bus.dmem_rdata;
        obs_addr = bus.mem_addr; obs_rmask = bus.mem_rmask; obs_wmask = bus.mem_wmask; obs_err = err;

        check("imem_resp", bus.imem_resp, (m_who == 1 && bus.mem_resp));
        check("imem_rdata", bus.imem_rdata, (m_who == 1 && bus.mem_resp) ? bus.mem_rdata : 32'd0);
        check("dmem_resp", bus.dmem_resp, (m_who == 2 && bus.mem_resp));
        check("dmem_rdata", bus.dmem_rdata, (m_who == 2 && bus.mem_resp) ? bus.mem_rdata : 32'd0);
        check("mem_rmask", bus.mem_rmask, m_issue ? m_cur.rmask : 4'h0);
        check("mem_wmask", bus.mem_wmask, m_issue ? m_cur.wmask : 4'h0);
        if (m_who != 0) check("mem_addr", bus.mem_addr, m_cur.addr);
        if (m_who == 2) check("mem_wdata", bus.mem_wdata, m_cur.wdata);
        check("err", err, m_err);

        resp_here = bus.mem_resp && (m_who != 0);
        if (bus.mem_resp && m_who == 0) m_err = 1'b1;
        n_who = resp_here ? 0 : m_who;
        i_pulse = (bus.imem_rmask != 4'h0);
        d_pulse = (bus.dmem_rmask != 4'h0) || (bus.dmem_wmask != 4'h0);
        if (i_pulse) begin
            if (m_i_wait || n_who == 1) m_err = 1'b1;
            else begin m_i_wait = 1'b1; m_i_req = '{bus.imem_addr, bus.imem_rmask, 4'h0, 32'd0}; end
        end
        if (d_pulse) begin
            if (m_d_wait || n_who == 2) m_err = 1'b1;
            else begin m_d_wait = 1'b1; m_d_req = '{bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, bus.dmem_wdata}; end
        end
        grant = 0;
        if (n_who == 0) begin
            if (m_i_wait && (!m_d_wait || m_streak >= DPRIO)) grant = 1;
            else if (m_d_wait) grant = 2;
        end
        if (grant == 1 || !m_i_wait) m_streak = 0;
        else if (grant == 2) m_streak = (m_streak + 1 > DPRIO) ? DPRIO : m_streak + 1;
        m_issue = 1'b0;
        if (grant == 1) begin m_cur = m_i_req; m_i_wait = 1'b0; n_who = 1; m_issue = 1'b1; end
        if (grant == 2) begin m_cur = m_d_req; m_d_wait = 1'b0; n_who = 2; m_issue = 1'b1; end
        if (grant != 0) mem_delay = $urandom_range(0, 2);
        m_who = n_who;

        @(posedge clk); #1;
        clear_inputs();
        if (auto_mem && m_who != 0 && !m_issue) begin
            if (mem_delay == 0) begin bus.mem_resp = 1'b1; bus.mem_rdata = $urandom(); end
            else mem_delay--;
        end
    endtask

    task automatic rand_pulses(input bit legal);
        logic [31:0] t;
        bit i_free, d_free;
        i_free = !(m_i_wait || (m_who == 1 && !bus.mem_resp));
        d_free = !(m_d_wait || (m_who == 2 && !bus.mem_resp));
        if ($urandom_range(0, 2) == 0 && (!legal || i_free)) begin
            t = $urandom(); bus.imem_addr = {t[31:2], 2'b00};
            bus.imem_rmask = 4'($urandom_range(1, 15));
        end
        if ($urandom_range(0, 2) == 0 && (!legal || d_free)) begin
            bus.dmem_addr = $urandom(); bus.dmem_wdata = $urandom();
            if ($urandom_range(0, 1) == 1) bus.dmem_rmask = 4'($urandom_range(1, 15));
            else bus.dmem_wmask = 4'($urandom_range(1, 15));
        end
        if (!legal && m_who == 0 && $urandom_range(0, 19) == 0) begin
            bus.mem_resp = 1'b1; bus.mem_rdata = $urandom();
        end
    endtask

    // Reset asserted just after a rising edge, held across one edge.
    task automatic apply_reset();
        rst = 1'b0;
        #1;
        check("rst_mem_rmask", bus.mem_rmask, 4'h0);
        check("rst_mem_wmask", bus.mem_wmask, 4'h0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_err", err, 1'b0);
        model_reset();
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    int d_cnt, rounds, guard;

    initial begin
        rst = 1'b0;
        bus.imem_addr = 32'd0; bus.dmem_addr = 32'd0; bus.dmem_wdata = 32'd0; bus.mem_rdata = 32'd0;
        clear_inputs();
        auto_mem = 1'b0; mem_delay = 0;
        model_reset();
        #2;
        check("rst_imem_resp", bus.imem_resp, 1'b0);
        check("rst_dmem_resp", bus.dmem_resp, 1'b0);
        check("rst_mask", {bus.mem_rmask, bus.mem_wmask}, 8'h00);
        check("rst_err0", err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Single imem read, first grant right after reset release.
        bus.imem_addr = 32'h1eceb000; bus.imem_rmask = 4'hF; step();
        step();
        check("t26_addr", obs_addr, 32'h1eceb000);
        check("t26_rmask", obs_rmask, 4'hF);
        step();
        check("t26_rmask_off", obs_rmask, 4'h0);
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h00000013; step();
        check("t26_resp", obs_i_resp, 1'b1);
        check("t26_rdata", obs_i_rdata, 32'h00000013);
        step();
        check("t26_resp_off", obs_i_resp, 1'b0);

        // Simultaneous pulses: dmem first, imem right after dmem's response.
        bus.imem_addr = 32'h100; bus.imem_rmask = 4'hF;
        bus.dmem_addr = 32'h200; bus.dmem_wmask = 4'h3; bus.dmem_wdata = 32'hABCD; step();
        step();
        check("t27_d_addr", obs_addr, 32'h200);
        check("t27_d_wmask", obs_wmask, 4'h3);
        step();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h55; step();
        check("t27_d_resp", obs_d_resp, 1'b1);
        step();
        check("t27_i_addr", obs_addr, 32'h100);
        check("t27_i_rmask", obs_rmask, 4'hF);
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h66; step();
        check("t27_i_resp", obs_i_resp, 1'b1);
        step();

        // Starvation bound: two rounds of dmem streaming against a re-requesting imem.
        auto_mem = 1'b1;
        bus.imem_addr = 32'h300; bus.imem_rmask = 4'hF;
        bus.dmem_addr = 32'h400; bus.dmem_wmask = 4'hF; bus.dmem_wdata = $urandom(); step();
        d_cnt = 0; rounds = 0; guard = 0;
        while (rounds < 2 && guard < 200) begin
            bit d_again, i_again;
            d_again = bus.mem_resp && m_who == 2;
            i_again = bus.mem_resp && m_who == 1;
            if (d_again) begin bus.dmem_addr = 32'h400; bus.dmem_wmask = 4'hF; bus.dmem_wdata = $urandom(); end
            if (i_again) begin bus.imem_addr = 32'h300; bus.imem_rmask = 4'hF; end
            step();
            if (obs_rmask != 4'h0) begin
                check("t28_dstreak", d_cnt, 4);
                d_cnt = 0; rounds++;
            end else if (obs_wmask != 4'h0) d_cnt++;
            guard++;
        end
        if (rounds < 2) check("t28_timeout", 1'b0, 1'b1);
        guard = 0;
        while ((m_who != 0 || m_i_wait || m_d_wait) && guard < 50) begin step(); guard++; end
        auto_mem = 1'b0;
        step();

        // Second dmem pulse while the first is in flight is dropped and flags err.
        bus.dmem_addr = 32'h40; bus.dmem_rmask = 4'hF; step();
        bus.dmem_addr = 32'h80; bus.dmem_rmask = 4'hF; step();
        check("t29_addr", obs_addr, 32'h40);
        step();
        check("t29_err", obs_err, 1'b1);
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'h77; step();
        step();
        check("t29_no_reissue", {obs_rmask, obs_wmask}, 8'h00);
        repeat (3) step();
        check("t29_err_sticky", obs_err, 1'b1);
        apply_reset();

        // Reset in the issue cycle of a dmem write, then a late memory response.
        bus.dmem_addr = 32'h500; bus.dmem_wmask = 4'hF; bus.dmem_wdata = 32'h1234; step();
        check("t30_issued", bus.mem_wmask, 4'hF);
        apply_reset();
        bus.mem_resp = 1'b1; bus.mem_rdata = 32'hDEAD; step();
        check("t30_no_dresp", obs_d_resp, 1'b0);
        check("t30_no_iresp", obs_i_resp, 1'b0);
        step();
        check("t30_err", obs_err, 1'b1);
        apply_reset();

        // Random legal traffic: err must stay low throughout.
        auto_mem = 1'b1;
        repeat (600) begin step(); rand_pulses(1'b1); end
        apply_reset();
        // Random traffic including dropped pulses and stray responses.
        repeat (400) begin step(); rand_pulses(1'b0); end
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
